// File: rtl/fft_stage_ctrl.sv
// rtl/fft_stage_ctrl.sv - radix-2 DIF FFT stage sequencer with read/butterfly/write-back alignment
module fft_stage_ctrl #(
    parameter int LOG2N  = 10,
    parameter int RD_LAT = 1,
    localparam int STW   = $clog2(LOG2N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [STW-1:0]   stage,
    output logic             rd_en,
    output logic [LOG2N-1:0] rd_addr_a,
    output logic [LOG2N-1:0] rd_addr_b,
    output logic [LOG2N-2:0] tw_addr,
    output logic             bf_enable,
    output logic             wr_en,
    output logic [LOG2N-1:0] wr_addr_a,
    output logic [LOG2N-1:0] wr_addr_b
);

    localparam int DW = $clog2(RD_LAT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [LOG2N-2:0] KMAX  = '1;
    localparam logic [STW-1:0]   SLAST = STW'(LOG2N - 1);
    localparam logic [DW-1:0]    DLAST = DW'(RD_LAT);
    localparam logic [LOG2N-1:0] ONE   = 1;

    logic [1:0]       state_q, state_d;
    logic [STW-1:0]   s_q, s_d;
    logic [LOG2N-2:0] k_q, k_d;
    logic [DW-1:0]    dcnt_q, dcnt_d;

    logic [LOG2N-1:0] rd_addr_a_q, rd_addr_b_q;
    logic [LOG2N-2:0] tw_addr_q;

    logic [STW-1:0]   sh;
    logic [LOG2N-1:0] span, pos, grp, addr_a_nx, addr_b_nx;
    logic [LOG2N-2:0] tw_nx;

    logic [RD_LAT:0]  pv_q;
    logic [LOG2N-1:0] pa_q [RD_LAT+1];
    logic [LOG2N-1:0] pb_q [RD_LAT+1];

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        k_d     = k_q;
        dcnt_d  = dcnt_q;
        case (state_q)
            S_IDLE: begin
                s_d = '0;
                k_d = '0;
                if (start) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (k_q == KMAX) begin
                    state_d = S_DRAIN;
                    dcnt_d  = '0;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_DRAIN: begin
                // Last write of this stage lands in the final drain cycle
                if (dcnt_q == DLAST) begin
                    if (s_q == SLAST) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                        s_d     = s_q + 1'b1;
                        k_d     = '0;
                    end
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                s_d     = '0;
            end
        endcase
    end

    // Addresses are computed for the pair about to be issued, so they register in step with RUN
    always_comb begin
        sh        = SLAST - s_d;
        span      = ONE << sh;
        pos       = {1'b0, k_d} & (span - ONE);
        grp       = {1'b0, k_d} >> sh;
        addr_a_nx = (grp << (int'(sh) + 1)) + pos;
        addr_b_nx = addr_a_nx + span;
        tw_nx     = (LOG2N-1)'(pos << s_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            s_q         <= '0;
            k_q         <= '0;
            dcnt_q      <= '0;
            rd_addr_a_q <= '0;
            rd_addr_b_q <= '0;
            tw_addr_q   <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            k_q     <= k_d;
            dcnt_q  <= dcnt_d;
            if (state_d == S_RUN) begin
                rd_addr_a_q <= addr_a_nx;
                rd_addr_b_q <= addr_b_nx;
                tw_addr_q   <= tw_nx;
            end
        end
    end

    // Read-to-butterfly-to-writeback delay line; cleared on reset so in-flight reads are dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv_q <= '0;
            for (int i = 0; i <= RD_LAT; i++) begin
                pa_q[i] <= '0;
                pb_q[i] <= '0;
            end
        end else begin
            pv_q    <= {pv_q[RD_LAT-1:0], rd_en};
            pa_q[0] <= rd_addr_a_q;
            pb_q[0] <= rd_addr_b_q;
            for (int i = 1; i <= RD_LAT; i++) begin
                pa_q[i] <= pa_q[i-1];
                pb_q[i] <= pb_q[i-1];
            end
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign stage     = s_q;
    assign rd_en     = (state_q == S_RUN);
    assign rd_addr_a = rd_addr_a_q;
    assign rd_addr_b = rd_addr_b_q;
    assign tw_addr   = tw_addr_q;
    assign bf_enable = pv_q[RD_LAT-1];
    assign wr_en     = pv_q[RD_LAT];
    assign wr_addr_a = pa_q[RD_LAT];
    assign wr_addr_b = pb_q[RD_LAT];

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// tb/tb_fft_stage_ctrl.sv - scoreboard bench for fft_stage_ctrl sequencing, pipeline and RAM result
module tb_fft_stage_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rst_n_v;
    logic [2:0] start_v;

    // units 0 and 1: LOG2N=3 with RD_LAT=1 and RD_LAT=2
    logic       busy_w [2];
    logic       done_w [2];
    logic       rd_w   [2];
    logic       bf_w   [2];
    logic       wr_w   [2];
    logic [1:0] stg_w  [2];
    logic [2:0] ra_w   [2];
    logic [2:0] rb_w   [2];
    logic [2:0] wa_w   [2];
    logic [2:0] wb_w   [2];
    logic [1:0] tw_w   [2];

    for (genvar u = 0; u < 2; u++) begin : g_u
        fft_stage_ctrl #(.LOG2N(3), .RD_LAT(u + 1)) dut (
            .clk(clk), .rst_n(rst_n_v[u]), .start(start_v[u]),
            .busy(busy_w[u]), .done(done_w[u]), .stage(stg_w[u]),
            .rd_en(rd_w[u]), .rd_addr_a(ra_w[u]), .rd_addr_b(rb_w[u]),
            .tw_addr(tw_w[u]), .bf_enable(bf_w[u]), .wr_en(wr_w[u]),
            .wr_addr_a(wa_w[u]), .wr_addr_b(wb_w[u])
        );
    end

    // unit 2: LOG2N=4, RD_LAT=1 driving a RAM and butterfly model
    logic       c_busy, c_done, c_rd, c_bf, c_wr;
    logic [1:0] c_stg;
    logic [3:0] c_ra, c_rb, c_wa, c_wb;
    logic [2:0] c_tw;

    fft_stage_ctrl #(.LOG2N(4), .RD_LAT(1)) dut_c (
        .clk(clk), .rst_n(rst_n_v[2]), .start(start_v[2]),
        .busy(c_busy), .done(c_done), .stage(c_stg),
        .rd_en(c_rd), .rd_addr_a(c_ra), .rd_addr_b(c_rb),
        .tw_addr(c_tw), .bf_enable(c_bf), .wr_en(c_wr),
        .wr_addr_a(c_wa), .wr_addr_b(c_wb)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        int u;
        int a;
        int b;
        int t;
        int rel;
    } ev_t;

    ev_t rdq[$];
    ev_t bfq[$];
    ev_t wrq[$];
    ev_t doneq[$];
    ev_t busyq[$];
    int  ramq[$];

    int a_tab[12] = '{0, 1, 2, 3, 0, 1, 4, 5, 0, 2, 4, 6};
    int b_tab[12] = '{4, 5, 6, 7, 2, 3, 6, 7, 1, 3, 5, 7};
    int t_tab[12] = '{0, 1, 2, 3, 0, 2, 0, 2, 0, 0, 0, 0};

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int t0[3];
    int bf_cnt[2];
    int wr_cnt[2];
    int busy_cnt[2];
    logic busy_prev[2];

    task automatic push_run(input int u);
        int lat;
        int period;
        lat    = u + 1;
        period = 4 + lat + 1;
        for (int s = 0; s < 3; s++) begin
            for (int k = 0; k < 4; k++) begin
                int i;
                int rel;
                i   = s * 4 + k;
                rel = s * period + k;
                rdq.push_back('{u, a_tab[i], b_tab[i], t_tab[i], rel});
                bfq.push_back('{u, 0, 0, 0, rel + lat});
                wrq.push_back('{u, a_tab[i], b_tab[i], 0, rel + lat + 1});
            end
        end
        doneq.push_back('{u, 0, 0, 0, 3 * period});
        busyq.push_back('{u, 0, 0, 0, 3 * period + 1});
    endtask

    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (!rst_n_v[u]) begin
                busy_cnt[u]  = 0;
                busy_prev[u] = 1'b0;
            end else begin
                int  rel;
                ev_t e;
                rel = cyc - t0[u];
                if (rd_w[u]) begin
                    if (rdq.size() == 0 || rdq[0].u != u) begin
                        chk($sformatf("u%0d rd_unexpected rel", u), rel, -1);
                    end else begin
                        e = rdq.pop_front();
                        chk($sformatf("u%0d rd_rel", u), rel, e.rel);
                        chk($sformatf("u%0d rd_addr_a", u), int'(ra_w[u]), e.a);
                        chk($sformatf("u%0d rd_addr_b", u), int'(rb_w[u]), e.b);
                        chk($sformatf("u%0d tw_addr", u), int'(tw_w[u]), e.t);
                    end
                end
                if (bf_w[u]) begin
                    bf_cnt[u]++;
                    if (bfq.size() == 0 || bfq[0].u != u) begin
                        chk($sformatf("u%0d bf_unexpected rel", u), rel, -1);
                    end else begin
                        e = bfq.pop_front();
                        chk($sformatf("u%0d bf_rel", u), rel, e.rel);
                    end
                end
                if (wr_w[u]) begin
                    wr_cnt[u]++;
                    if (wrq.size() == 0 || wrq[0].u != u) begin
                        chk($sformatf("u%0d wr_unexpected rel", u), rel, -1);
                    end else begin
                        e = wrq.pop_front();
                        chk($sformatf("u%0d wr_rel", u), rel, e.rel);
                        chk($sformatf("u%0d wr_addr_a", u), int'(wa_w[u]), e.a);
                        chk($sformatf("u%0d wr_addr_b", u), int'(wb_w[u]), e.b);
                    end
                end
                if (done_w[u]) begin
                    if (doneq.size() == 0 || doneq[0].u != u) begin
                        chk($sformatf("u%0d done_unexpected rel", u), rel, -1);
                    end else begin
                        e = doneq.pop_front();
                        chk($sformatf("u%0d done_rel", u), rel, e.rel);
                    end
                end
                if (busy_w[u]) busy_cnt[u]++;
                if (busy_prev[u] && !busy_w[u]) begin
                    if (busyq.size() == 0 || busyq[0].u != u) begin
                        chk($sformatf("u%0d busy_unexpected cycles", u), busy_cnt[u], -1);
                    end else begin
                        e = busyq.pop_front();
                        chk($sformatf("u%0d busy_cycles", u), busy_cnt[u], e.rel);
                    end
                    busy_cnt[u] = 0;
                end
                busy_prev[u] = busy_w[u];
            end
        end
    end

    // RAM, twiddle ROM and butterfly model for unit 2 (one-cycle read latency)
    real re_m[16];
    real im_m[16];
    real twr[8];
    real twi[8];
    real dar, dai, dbr, dbi, yar, yai, ybr, ybi;
    logic [2:0] twq;
    int  c_wr_cnt;

    initial begin
        for (int m = 0; m < 8; m++) begin
            twr[m] = $cos(2.0 * 3.14159265358979 * m / 16.0);
            twi[m] = -$sin(2.0 * 3.14159265358979 * m / 16.0);
        end
    end

    always @(posedge clk) begin
        if (!rst_n_v[2]) begin
            for (int i = 0; i < 16; i++) begin
                re_m[i] <= (i == 0) ? 100.0 : 0.0;
                im_m[i] <= 0.0;
            end
            c_wr_cnt <= 0;
        end else begin
            if (c_rd) begin
                dar <= re_m[c_ra];
                dai <= im_m[c_ra];
                dbr <= re_m[c_rb];
                dbi <= im_m[c_rb];
                twq <= c_tw;
            end
            if (c_bf) begin
                yar <= dar + dbr;
                yai <= dai + dbi;
                ybr <= (dar - dbr) * twr[twq] - (dai - dbi) * twi[twq];
                ybi <= (dar - dbr) * twi[twq] + (dai - dbi) * twr[twq];
            end
            if (c_wr) begin
                re_m[c_wa] <= yar;
                im_m[c_wa] <= yai;
                re_m[c_wb] <= ybr;
                im_m[c_wb] <= ybi;
                c_wr_cnt   <= c_wr_cnt + 1;
            end
        end
    end

    task automatic start_pulse(input int u);
        @(negedge clk);
        start_v[u] = 1'b1;
        @(posedge clk);
        #1;
        start_v[u] = 1'b0;
        t0[u] = cyc;
    endtask

    function automatic logic get_done(input int u);
        if (u == 2) return c_done;
        return done_w[u];
    endfunction

    task automatic wait_done(input int u);
        int n;
        n = 0;
        while (!get_done(u) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("u%0d done_seen_within_bound", u), int'(n < 200), 1);
    endtask

    initial begin
        rst_n_v = 3'b000;
        start_v = 3'b000;
        for (int u = 0; u < 2; u++) begin
            t0[u] = 0; bf_cnt[u] = 0; wr_cnt[u] = 0;
            busy_cnt[u] = 0; busy_prev[u] = 1'b0;
        end
        t0[2] = 0;
        #22;
        chk("reset_outputs_u0", int'({busy_w[0], done_w[0], stg_w[0], rd_w[0], ra_w[0], rb_w[0],
                                      tw_w[0], bf_w[0], wr_w[0], wa_w[0], wb_w[0]}), 0);
        @(negedge clk);
        rst_n_v = 3'b111;

        // full transform on unit 0 with a start pulse during stage 1 that must be ignored
        start_pulse(0);
        push_run(0);
        repeat (8) @(negedge clk);
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        wait_done(0);
        repeat (10) @(negedge clk);
        chk("u0 busy_after_done", int'(busy_w[0]), 0);
        chk("u0 stage_after_done", int'(stg_w[0]), 0);

        // RD_LAT=2 pipeline alignment
        start_pulse(1);
        push_run(1);
        wait_done(1);
        repeat (5) @(negedge clk);
        chk("u1 bf_pulses", bf_cnt[1], 12);
        chk("u1 wr_pulses", wr_cnt[1], 12);

        // asynchronous reset in stage 1 with a write still in flight
        start_pulse(0);
        push_run(0);
        repeat (8) @(negedge clk);
        #2;
        rst_n_v[0] = 1'b0;
        #1;
        chk("u0 outputs_in_reset", int'({busy_w[0], done_w[0], stg_w[0], rd_w[0], ra_w[0], rb_w[0],
                                         tw_w[0], bf_w[0], wr_w[0], wa_w[0], wb_w[0]}), 0);
        rdq.delete(); bfq.delete(); wrq.delete(); doneq.delete(); busyq.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("u0 wr_en_held_in_reset", int'(wr_w[0]), 0);
        end
        @(negedge clk);
        rst_n_v[0] = 1'b1;
        start_pulse(0);
        push_run(0);
        wait_done(0);
        repeat (5) @(negedge clk);

        // impulse through the RAM model must yield a flat spectrum
        for (int i = 0; i < 16; i++) ramq.push_back(100000);
        start_pulse(2);
        wait_done(2);
        repeat (4) @(negedge clk);
        chk("c wr_pulses", c_wr_cnt, 32);
        for (int i = 0; i < 16; i++) begin
            int exp_v;
            exp_v = ramq.pop_front();
            chk($sformatf("c ram_re[%0d]x1000", i), $rtoi(re_m[i] * 1000.0), exp_v);
            chk($sformatf("c ram_im[%0d]x1000", i), $rtoi(im_m[i] * 1000.0), 0);
        end

        chk("rdq_leftover", rdq.size(), 0);
        chk("bfq_leftover", bfq.size(), 0);
        chk("wrq_leftover", wrq.size(), 0);
        chk("doneq_leftover", doneq.size(), 0);
        chk("busyq_leftover", busyq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
